// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its environment
// (PLL wrapper, system reset tree, control logic).
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ready;
    logic       lock_fail;
    logic       lock_lost;
    logic [2:0] retry_count;

    modport master (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output sys_rst,
        output pll_ready,
        output lock_fail,
        output lock_lost,
        output retry_count
    );

    modport slave (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  sys_rst,
        input  pll_ready,
        input  lock_fail,
        input  lock_lost,
        input  retry_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, debounces the synchronized locked flag, releases the
// system reset once lock is stable, retries on timeout and latches failure.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 7,
    parameter int CNT_W              = 16
) (
    input logic                   refclk,
    input logic                   rst,
    pll_lock_supervisor_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             lost_d;

    logic pll_rst_q, sys_rst_q, pll_ready_q, lock_fail_q, lock_lost_q;

    // pll_locked comes from the PLL's own clock domain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET_PLL;
            cnt_q   <= '0;
            retry_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // restart overrides everything, including a lock loss seen in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = 1'b0;
        if (bus.restart) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = 3'd0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET_PLL;
                            retry_d = retry_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_STABILIZE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = '0;
                        retry_d = 3'd0;
                        lost_d  = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET_PLL;
                    cnt_d   = '0;
                    retry_d = 3'd0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they move on the same edge as the state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
            sys_rst_q   <= (state_d != S_RUN);
            pll_ready_q <= (state_d == S_RUN);
            lock_fail_q <= (state_d == S_FAIL);
            lock_lost_q <= lost_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.pll_ready   = pll_ready_q;
    assign bus.lock_fail   = lock_fail_q;
    assign bus.lock_lost   = lock_lost_q;
    assign bus.retry_count = retry_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the rst/locked interface of the team's PLL wrapper from the reference-clock side. It drives the PLL reset pulse and watches the asynchronous locked flag. On lock it debounces, then releases a system reset for downstream logic. On timeout it retries the PLL reset, and it latches a failure flag once retries are exhausted. It sits between the board reset/refclk and the PLL instance plus the system reset tree.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 50000, refclk cycles to wait for lock per attempt (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release
MAX_RETRIES, 7, PLL re-reset attempts after the first attempt (0..7)
CNT_W, 16, shared counter width; must hold max(all cycle parameters)-1

Ports:
refclk  in  1  free-running reference clock, sole clock
rst  in  1  asynchronous active-high reset
pll_locked  in  1  PLL locked flag, asynchronous to refclk
restart  in  1  synchronous one-cycle request to restart lock sequence
pll_rst  out  1  reset to PLL, active-high
sys_rst  out  1  system reset, active-high; low only in RUN
pll_ready  out  1  high only in RUN
lock_fail  out  1  sticky; high only in FAIL
lock_lost  out  1  one-cycle pulse when lock drops in RUN
retry_count  out  3  retries consumed in current sequence

Behaviour:
- Reset (async, rst=1): state=RESET_PLL, counter=0, sync flops=0, retry_count=0.
  - Outputs during reset: pll_rst=1, sys_rst=1, pll_ready=0, lock_fail=0, lock_lost=0.
- pll_locked passes through a 2-flop synchronizer (locked_s) and is only used as locked_s.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state.
- States and transitions:
  - RESET_PLL:
    - pll_rst=1.
    - Counter counts 0..RST_PULSE_CYCLES-1; on the last count go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK:
    - pll_rst=0.
    - locked_s=1: go to STABILIZE and clear the counter.
    - Otherwise at counter==LOCK_TIMEOUT-1:
      - retry_count==MAX_RETRIES: go to FAIL.
      - Else increment retry_count and go to RESET_PLL.
  - STABILIZE:
    - locked_s=0: go to WAIT_LOCK, counter cleared, timeout restarts, retry_count unchanged.
    - At counter==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN and clear retry_count.
  - RUN:
    - sys_rst=0, pll_ready=1.
    - locked_s=0: lock_lost=1 for exactly that edge's cycle, go to RESET_PLL with retry_count=0; sys_rst=1 on the same edge.
  - FAIL:
    - pll_rst=1, sys_rst=1, lock_fail=1.
    - Stays until restart or rst.
- restart=1 in any state:
  - Go to RESET_PLL with counter=0, retry_count=0, lock_fail cleared.
  - restart has priority over every other transition, including a same-cycle lock loss; lock_lost is not pulsed in that case.
- Boundaries:
  - Counter never wraps; it is cleared on every state change.
  - locked_s glitches shorter than 1 cycle after synchronization are not filtered further.
  - A lock arriving on the same cycle as the timeout count wins: go to STABILIZE.
  - Total pll_rst pulses before FAIL = MAX_RETRIES+1.

Test Plan:
All tests use RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. pll_locked tied 1, rst released -> pll_rst high for 4 cycles; sys_rst and pll_ready change on edge 13 after release (4+1+8); retry_count=0; lock_lost never pulses.
2. pll_locked tied 0 -> 3 pll_rst pulses each 4 cycles wide, separated by 20-cycle waits; retry_count steps 0,1,2; lock_fail=1 and pll_rst=1 at edge 72; state held for 100 further cycles.
3. From FAIL, pulse restart, then tie pll_locked=1 -> lock_fail clears on that edge; retry_count=0; sys_rst releases 13 edges later.
4. In RUN, drop pll_locked for 3 cycles -> lock_lost pulses once, 2-3 edges after the drop; sys_rst=1 and pll_rst=1 on the same edge; re-lock restores RUN after the full sequence.
5. During STABILIZE, drop pll_locked at stable count 5 -> returns to WAIT_LOCK; retry_count unchanged; RUN only after 8 fresh consecutive locked cycles.
6. Assert rst asynchronously mid-STABILIZE -> all outputs return to reset values before the next refclk edge.
